// File: rtl/button_event_controller.sv
// Button scan controller: synchronise, tick-filter, round-robin arbitrate level changes into an event FIFO.
// Optional: define BTN_EVT_TIMESTAMP_EN to add a 16-bit tick timestamp (evt_time) to every event.
module button_event_controller #(
  parameter int NUM_BTN    = 4,
  parameter int CLK_DIV    = 1000,
  parameter int STABLE_CNT = 4,
  parameter int FIFO_DEPTH = 4,
  localparam int ID_W      = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] button,
  input  logic               enable,
  output logic [NUM_BTN-1:0] level,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic [ID_W-1:0]    evt_id,
  output logic               evt_press,
`ifdef BTN_EVT_TIMESTAMP_EN
  output logic [15:0]        evt_time,
`endif
  output logic               overflow,
  input  logic               clear_ovf
);

  localparam int PW = $clog2(CLK_DIV);
  localparam int CW = $clog2(STABLE_CNT + 1);
  localparam int AW = $clog2(FIFO_DEPTH);

  function automatic logic [ID_W-1:0] rr_index(input logic [ID_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_BTN) s = s - NUM_BTN;
    return ID_W'(s);
  endfunction

  logic [NUM_BTN-1:0] sync_q1, sync_q2;
  logic [PW-1:0]      presc;
  logic               tick;
  logic [CW-1:0]      cnt [NUM_BTN];
  logic [NUM_BTN-1:0] chg;
  logic [NUM_BTN-1:0] pend, pdir;
  logic [ID_W-1:0]    rr_start;
  logic               grant_valid;
  logic [ID_W-1:0]    grant_id;
  logic [NUM_BTN-1:0] grant_sel;
  logic               loss;
  logic               stage_valid;
  logic [ID_W-1:0]    stage_id;
  logic               stage_press;
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [AW:0]        count;
  logic               push, pop, room;
  logic [ID_W-1:0]    mem_id    [FIFO_DEPTH];
  logic               mem_press [FIFO_DEPTH];

  // NOTE: every clocked process uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= button;
      sync_q2 <= sync_q1;
    end
  end

  assign tick = enable && (presc == PW'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       presc <= '0;
    else if (!enable) presc <= '0;
    else if (tick)    presc <= '0;
    else              presc <= presc + 1'b1;
  end

  // A channel's level flips on the tick that completes STABLE_CNT differing samples.
  always_comb begin
    // NOTE: combinational outputs get a default before any branch so no latch is inferred.
    chg = '0;
    for (int i = 0; i < NUM_BTN; i++)
      chg[i] = tick && (sync_q2[i] != level[i]) && (cnt[i] == CW'(STABLE_CNT - 1));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level <= '0;
      for (int i = 0; i < NUM_BTN; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        if (!enable) begin
          cnt[i] <= '0;
        end else if (tick) begin
          if (sync_q2[i] == level[i]) begin
            cnt[i] <= '0;
          end else if (chg[i]) begin
            cnt[i]   <= '0;
            level[i] <= sync_q2[i];
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end
      end
    end
  end

  // Room counts the staged event too, so a grant can never overrun the FIFO.
  assign pop  = evt_valid && evt_ready;
  assign push = stage_valid;
  assign room = (int'(count) + int'(stage_valid)) < (FIFO_DEPTH + int'(pop));

  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    grant_sel   = '0;
    if (room) begin
      for (int k = 0; k < NUM_BTN; k++) begin
        if (!grant_valid && pend[rr_index(rr_start, k)]) begin
          grant_valid = 1'b1;
          grant_id    = rr_index(rr_start, k);
        end
      end
    end
    if (grant_valid) grant_sel[grant_id] = 1'b1;
  end

  assign loss = |(chg & pend & ~grant_sel);

  // A fresh change on a still-pending channel cancels both events; a change that
  // coincides with that channel's grant re-arms the pend instead.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend     <= '0;
      pdir     <= '0;
      rr_start <= '0;
      overflow <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        if (chg[i]) begin
          if (grant_sel[i] || !pend[i]) begin
            pend[i] <= 1'b1;
            pdir[i] <= sync_q2[i];
          end else begin
            pend[i] <= 1'b0;
          end
        end else if (grant_sel[i]) begin
          pend[i] <= 1'b0;
        end
      end
      if (grant_valid) rr_start <= rr_index(grant_id, 1);
      if (loss)           overflow <= 1'b1;
      else if (clear_ovf) overflow <= 1'b0;
    end
  end

`ifdef BTN_EVT_TIMESTAMP_EN
  logic [15:0] tick_time;
  logic [15:0] stage_time;
  logic [15:0] mem_time [FIFO_DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    tick_time <= '0;
    else if (tick) tick_time <= tick_time + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)           stage_time <= '0;
    else if (grant_valid) stage_time <= tick_time;
  end

  always_ff @(posedge clk) begin
    if (push) mem_time[wr_ptr] <= stage_time;
  end

  assign evt_time = evt_valid ? mem_time[rd_ptr] : '0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stage_valid <= 1'b0;
      stage_id    <= '0;
      stage_press <= 1'b0;
    end else begin
      stage_valid <= grant_valid;
      if (grant_valid) begin
        stage_id    <= grant_id;
        stage_press <= pdir[grant_id];
      end
    end
  end

  // NOTE: FIFO storage has no reset; valid comes only from count, and outputs are gated while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_id[wr_ptr]    <= stage_id;
      mem_press[wr_ptr] <= stage_press;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  assign evt_valid = (count != '0);
  assign evt_id    = evt_valid ? mem_id[rd_ptr]    : '0;
  assign evt_press = evt_valid ? mem_press[rd_ptr] : 1'b0;

endmodule

// File: tb/tb_button_event_controller.sv
// Self-checking bench for button_event_controller: vector table plus hand sequences, event scoreboard.
module tb_button_event_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] button = '0;
  logic       enable = 1'b1;
  logic [3:0] level;
  logic       evt_valid;
  logic       evt_ready = 1'b1;
  logic [1:0] evt_id;
  logic       evt_press;
  logic       overflow;
  logic       clear_ovf = 1'b0;

  button_event_controller #(
    .NUM_BTN(4), .CLK_DIV(4), .STABLE_CNT(3), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset), .button(button), .enable(enable), .level(level),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_id(evt_id),
    .evt_press(evt_press), .overflow(overflow), .clear_ovf(clear_ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] id;
    logic       press;
  } evt_t;

  typedef struct {
    logic [3:0] btn;
    logic [3:0] exp_level;
    int         exp_n;
  } vec_t;

  evt_t exp_q[$];
  evt_t mon_e;
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_evt(input int id, input logic press);
    evt_t e;
    e.id    = 2'(id);
    e.press = press;
    exp_q.push_back(e);
  endtask

  // Scoreboard: every accepted handshake must match the oldest expected event.
  always @(negedge clk) begin
    if (reset === 1'b1 && evt_valid && evt_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL evt_unexpected: got id=%0d press=%0b expected none", evt_id, evt_press);
      end else begin
        mon_e = exp_q.pop_front();
        check("evt_id", 32'(evt_id), 32'(mon_e.id));
        check("evt_press", 32'(evt_press), 32'(mon_e.press));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vecs[6];
    logic [3:0] prev, chgm;
    int         rr, last, lat, run;
    bit         found;

    vecs[0] = '{4'b1111, 4'b1111, 4};
    vecs[1] = '{4'b0000, 4'b0000, 4};
    vecs[2] = '{4'b0101, 4'b0101, 2};
    vecs[3] = '{4'b0000, 4'b0000, 2};
    vecs[4] = '{4'b0110, 4'b0110, 2};
    vecs[5] = '{4'b0000, 4'b0000, 2};

    #2;
    check("rst_level", 32'(level), 0);
    check("rst_evt_valid", 32'(evt_valid), 0);
    check("rst_evt_id", 32'(evt_id), 0);
    check("rst_evt_press", 32'(evt_press), 0);
    check("rst_overflow", 32'(overflow), 0);
    step(3);
    reset = 1'b1;
    step(2);

    // Simultaneous changes: events leave in round-robin order on consecutive cycles.
    rr = 0;
    for (int i = 0; i < 6; i++) begin
      prev   = button;
      button = vecs[i].btn;
      chgm   = prev ^ vecs[i].btn;
      last   = rr;
      for (int k = 0; k < 4; k++) begin
        if (chgm[(rr + k) % 4]) begin
          expect_evt((rr + k) % 4, vecs[i].btn[(rr + k) % 4]);
          last = (rr + k) % 4;
        end
      end
      rr = (last + 1) % 4;
      found = 1'b0;
      for (int n = 0; n < 40; n++) begin
        @(negedge clk);
        if (evt_valid) begin
          found = 1'b1;
          break;
        end
      end
      check("vec_valid_seen", 32'(found), 1);
      run = 0;
      if (found) begin
        do begin
          run++;
          @(negedge clk);
        end while (evt_valid && run < 10);
      end
      check("vec_burst_len", 32'(run), 32'(vecs[i].exp_n));
      step(4);
      check("vec_level", 32'(level), 32'(vecs[i].exp_level));
    end
    check("vec_queue_drained", 32'(exp_q.size()), 0);

    // Clean press: latency window, then evt_valid two cycles after the level change.
    button[0] = 1'b1;
    expect_evt(0, 1'b1);
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (level[0]) begin
        lat = n;
        break;
      end
    end
    check("t1_latency_window", 32'(lat >= 11 && lat <= 14), 1);
    step(1);
    check("t1_valid_not_yet", 32'(evt_valid), 0);
    step(1);
    check("t1_valid_two_after", 32'(evt_valid), 1);
    step(6);
    button[0] = 1'b0;
    expect_evt(0, 1'b0);
    step(20);
    check("t1_release_level", 32'(level[0]), 0);

    // Bounce 1,0 one tick each, then hold: only the held phase produces a press.
    button[1] = 1'b1;
    step(4);
    button[1] = 1'b0;
    step(4);
    button[1] = 1'b1;
    step(8);
    check("t2_no_early_level", 32'(level[1]), 0);
    check("t2_no_early_evt", 32'(evt_valid), 0);
    expect_evt(1, 1'b1);
    step(20);
    check("t2_level_set", 32'(level[1]), 1);
    button[1] = 1'b0;
    expect_evt(1, 1'b0);
    step(24);
    check("t2_queue_drained", 32'(exp_q.size()), 0);

    // Backpressure: six changes on ch2/ch3 fill the FIFO and hold the last two pends.
    evt_ready = 1'b0;
    button = 4'b1100;
    expect_evt(2, 1'b1);
    expect_evt(3, 1'b1);
    step(24);
    button = 4'b0000;
    expect_evt(2, 1'b0);
    expect_evt(3, 1'b0);
    step(24);
    button = 4'b1100;
    expect_evt(2, 1'b1);
    expect_evt(3, 1'b1);
    step(24);
    check("t4_valid_full", 32'(evt_valid), 1);
    check("t4_head_id", 32'(evt_id), 2);
    check("t4_head_press", 32'(evt_press), 1);
    check("t4_no_overflow", 32'(overflow), 0);
    step(3);
    check("t4_head_stable", 32'(evt_id), 2);

    // Ch0 press then release while its pend is stuck behind a full FIFO: cancelled, overflow.
    button = 4'b1101;
    step(24);
    button = 4'b1100;
    step(24);
    check("t5_overflow_set", 32'(overflow), 1);
    check("t5_level0", 32'(level[0]), 0);
    clear_ovf = 1'b1;
    step(1);
    clear_ovf = 1'b0;
    check("t5_overflow_clear", 32'(overflow), 0);
    evt_ready = 1'b1;
    step(20);
    check("t5_drained", 32'(exp_q.size()), 0);
    button = 4'b0000;
    expect_evt(2, 1'b0);
    expect_evt(3, 1'b0);
    step(24);
    check("t5_release_drained", 32'(exp_q.size()), 0);

    // Scanning disabled: levels frozen, no events.
    enable = 1'b0;
    button = 4'b1000;
    step(30);
    check("en_level_frozen", 32'(level), 0);
    check("en_no_evt", 32'(evt_valid), 0);
    button = 4'b0000;
    enable = 1'b1;
    step(30);

    // Reset mid-scan with a held button.
    button = 4'b0100;
    step(5);
    reset = 1'b0;
    #1;
    check("t6_rst_level", 32'(level), 0);
    check("t6_rst_valid", 32'(evt_valid), 0);
    check("t6_rst_overflow", 32'(overflow), 0);
    step(3);
    reset = 1'b1;
    expect_evt(2, 1'b1);
    step(30);
    check("t6_level_after", 32'(level), 32'(4'b0100));
    check("t6_one_event", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
